pll_serial_rx: RTL
==================

Name: pll_serial_rx

Overview:
- Synchronous receiver and register model for the 3-wire PLL programming interface (CE, DAT, LE, serial clock).
- Lives in the board test/bring-up path.
  - Oversamples the serial lines in the system clock domain.
  - Shifts in 32-bit words MSB first.
  - On the LE rising edge, decodes the 3 LSB control bits and writes the word into one of six shadow registers.
- Used as a bus monitor and as the PLL stand-in for verifying the PLL programming FSM.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk/dat/le/ce inputs (legal values 2..4).
- NUM_REGS, 6, number of shadow registers. Only control codes 0..NUM_REGS-1 are valid.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- pll_sclk  input  1  serial clock from the programmer. Asynchronous to clk.
- pll_dat  input  1  serial data, MSB first.
- pll_le  input  1  load enable. Rising edge commits the shifted word.
- pll_ce  input  1  chip enable. Low holds the shift logic idle.
- reg_flat  output  32*NUM_REGS  shadow registers. Register n occupies [32n+31:32n].
- load_valid  output  1  one-cycle pulse when a word is committed.
- load_addr  output  3  register index of the last commit or error attempt.
- load_err  output  1  one-cycle pulse when a frame is rejected.
- err_code  output  2  reason for the last rejection: 1=length, 2=bad control code, 3=both.
- bit_count  output  6  bits shifted since the last LE edge. Saturates at 63.
- all_loaded  output  1  sticky. Set when all registers have been written and the last commit was to reg 0.

Behaviour:
- Reset values (rstn low, asynchronous):
  - All outputs 0.
  - Shift register 0.
  - Written-mask 0.
  - Synchronizer flops 0.
- Synchronizers:
  - pll_sclk, pll_dat, pll_le and pll_ce each pass through SYNC_STAGES flops.
  - One further flop per line provides the edge history.
- sclk rise: synced sclk is 1 and its previous value was 0.
  - Shift in synced dat (same synchronizer depth, so it is sample-aligned): shift <= {shift[30:0], dat}.
  - bit_count increments, saturating at 63.
  - Ignored while synced le is 1 or synced ce is 0.
- Input timing requirement:
  - sclk high and low phases each at least SYNC_STAGES+1 clk cycles.
  - dat stable for that window around the sclk rising edge.
- le rise (synced, ce=1): evaluate the word in the same cycle.
  - ctrl = shift[2:0]. load_addr <= ctrl.
  - bit_count == 32 and ctrl < NUM_REGS: write reg[ctrl] <= shift, set mask bit ctrl, pulse load_valid.
  - Otherwise: pulse load_err. err_code is bit0 = (bit_count != 32), bit1 = (ctrl >= NUM_REGS). No register changes.
  - Either way, bit_count <= 0 on the next cycle. The shift register is not cleared.
- Overlength frame: shift keeps the last 32 bits, but a count above 32 still gives a length error.
- all_loaded:
  - Set on a load_valid with ctrl==0 while the mask (including this write) is all ones.
  - Cleared only by reset.
- ce low (synced):
  - bit_count <= 0; shift events and le events are ignored.
  - reg_flat, mask and all_loaded are retained.
- sclk rise and le rise in the same clk cycle: le is processed first; the sclk edge is dropped. Cannot occur with a legal programmer.
- Latency:
  - Input pin edge to internal action: SYNC_STAGES+1 clk cycles.
  - load_valid / load_err: registered, asserted the cycle after the le-rise detect.
  - reg_flat updates in the same cycle that load_valid asserts.
- Reset mid-frame: everything clears.
  - The next frame starts counting from 0.
  - A partial frame then rising le produces a length error.

Optional Feature:
- Macro: PLL_RX_GLITCH_FILTER_EN.
- Defined:
  - A synced sclk/le level change is accepted only after it has held the new level for 2 consecutive clk cycles.
  - Adds 1 cycle of latency.
  - Minimum legal phase becomes SYNC_STAGES+2 cycles.
  - Single-cycle pulses on sclk or le are ignored entirely.
- Undefined: raw synchronized edges are used as described above.

Test Plan:
- Shift 0x00580005 (32 bits), then pulse le → load_valid for 1 cycle, load_addr=5, reg5=0x00580005, err_code unchanged, bit_count returns to 0.
- Send the sequence reg5..reg0 as 0x580005, 0x9C803C, 0x4B3, 0x4E42, 0x8008011, 0x500000, with sclk half-period 5 clk → six load_valid pulses, reg_flat matches all six values, all_loaded=1 after the reg0 commit and not before.
- Shift 31 bits, then le → load_err, err_code=1, no register change. Shift 32 bits with ctrl=6 → err_code=2, load_addr=6. Shift 33 bits with ctrl=7 → err_code=3.
- Hold pll_ce=0 and toggle sclk 32 times, then le → no pulses, bit_count=0. Raise ce and send 0x4B3 → reg3=0x4B3.
- Assert rstn low after 16 bits of a frame, release it, then send a full 0x4E42 frame → reg2=0x4E42, all other registers 0, all_loaded=0.
- With PLL_RX_GLITCH_FILTER_EN defined, inject 1-cycle sclk glitches mid-frame → bit_count unaffected and the frame commits correctly. Without the macro, a glitch long enough to pass the synchronizer adds a bit and the frame produces err_code=1.

Source files
------------

// File: rtl/pll_serial_rx_if.sv
// Serial programming lines of the 3-wire PLL interface (plus chip enable).
// The programmer drives the lines (master); the receiver samples them (slave).
interface pll_serial_rx_if;
    logic pll_sclk;
    logic pll_dat;
    logic pll_le;
    logic pll_ce;

    modport master (output pll_sclk, output pll_dat, output pll_le, output pll_ce);
    modport slave  (input  pll_sclk, input  pll_dat, input  pll_le, input  pll_ce);
endinterface

// File: rtl/pll_serial_rx.sv
// PLL 3-wire serial receiver and shadow-register model.
// Oversamples sclk/dat/le/ce in the clk domain, shifts 32-bit words MSB first
// and commits them on the le rising edge into one of NUM_REGS shadow registers
// selected by the 3 LSB control bits.
// Optional build macro: PLL_RX_GLITCH_FILTER_EN -- when defined, synced sclk/le
// level changes must hold for 2 clk cycles before being accepted.
module pll_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    pll_serial_rx_if.slave           pins,
    output logic [32*NUM_REGS-1:0]   reg_flat,
    output logic                     load_valid,
    output logic [2:0]               load_addr,
    output logic                     load_err,
    output logic [1:0]               err_code,
    output logic [5:0]               bit_count,
    output logic                     all_loaded
);

    // Line order inside the packed vectors: 0=sclk, 1=dat, 2=le, 3=ce.
    logic [3:0] pin_vec;
    logic [3:0] sync_reg [SYNC_STAGES];
    logic [3:0] line_s;
    logic [3:0] hist_reg;

    assign pin_vec = {pins.pll_ce, pins.pll_le, pins.pll_dat, pins.pll_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First synchronizer stage samples the asynchronous pins.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) sync_reg[0] <= '0;
                    else       sync_reg[0] <= pin_vec;
                end
            end else begin : g_rest
                // Remaining stages resolve metastability.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) sync_reg[gi] <= '0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign line_s = sync_reg[SYNC_STAGES-1];

    // Edge history: one extra flop per line behind the synchronizer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hist_reg <= '0;
        else       hist_reg <= line_s;
    end

    logic sclk_rise;
    logic le_rise;
    logic le_level;
    logic dat_bit;
    logic ce_level;
    logic unused_hist;

    assign ce_level    = line_s[3];
    assign unused_hist = hist_reg[3];

`ifdef PLL_RX_GLITCH_FILTER_EN
    logic sclk_filt_reg;
    logic le_filt_reg;

    // Accept a new sclk/le level only once two consecutive samples agree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_filt_reg <= 1'b0;
            le_filt_reg   <= 1'b0;
        end else begin
            if (line_s[0] == hist_reg[0]) sclk_filt_reg <= line_s[0];
            if (line_s[2] == hist_reg[2]) le_filt_reg   <= line_s[2];
        end
    end

    assign sclk_rise = line_s[0] & hist_reg[0] & ~sclk_filt_reg;
    assign le_rise   = line_s[2] & hist_reg[2] & ~le_filt_reg;
    assign le_level  = le_filt_reg;
    // Edge is confirmed one cycle late, so take dat from the history flop to stay aligned.
    assign dat_bit   = hist_reg[1];
`else
    assign sclk_rise = line_s[0] & ~hist_reg[0];
    assign le_rise   = line_s[2] & ~hist_reg[2];
    assign le_level  = line_s[2];
    assign dat_bit   = line_s[1];
`endif

    logic [31:0]         shift_reg;
    logic [2:0]          ctrl;
    logic                len_ok;
    logic                ctrl_ok;
    logic                commit;
    logic                all_after;
    logic [NUM_REGS-1:0] mask_vec;

    assign ctrl      = shift_reg[2:0];
    assign len_ok    = (bit_count == 6'd32);
    assign ctrl_ok   = ({29'd0, ctrl} < 32'(NUM_REGS));
    assign commit    = ce_level & le_rise & len_ok & ctrl_ok;
    // Mask as it will look including the current write (only consulted for ctrl==0).
    assign all_after = &(mask_vec | NUM_REGS'(1));

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [31:0] data_reg;
            logic        written_reg;

            // Shadow register gi and its written flag update on a valid commit to it.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    data_reg    <= '0;
                    written_reg <= 1'b0;
                end else if (commit && (ctrl == 3'(gi))) begin
                    data_reg    <= shift_reg;
                    written_reg <= 1'b1;
                end
            end

            assign reg_flat[32*gi +: 32] = data_reg;
            assign mask_vec[gi]          = written_reg;
        end
    endgenerate

    // Shift engine, frame evaluation and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            load_addr  <= '0;
            err_code   <= '0;
            all_loaded <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            if (!ce_level) begin
                bit_count <= '0;
            end else if (le_rise) begin
                // le wins over a coincident sclk edge; that sclk edge is dropped.
                load_addr <= ctrl;
                bit_count <= '0;
                if (len_ok && ctrl_ok) begin
                    load_valid <= 1'b1;
                    if (ctrl == 3'd0 && all_after) all_loaded <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                    err_code <= {~ctrl_ok, ~len_ok};
                end
            end else if (sclk_rise && !le_level) begin
                shift_reg <= {shift_reg[30:0], dat_bit};
                if (bit_count != 6'd63) bit_count <= bit_count + 6'd1;
            end
        end
    end

endmodule
